gpio_port: RTL and testbench
============================

# gpio_port

Parametrised general-purpose I/O port with AVR-style DDR/PORT/PIN registers, toggle-on-PIN-write, input synchronisation, pull-up enables and a masked pin-change interrupt. Sits on the core's memory-mapped I/O bus in place of the fixed 8-bit output-only port register. It drives the pad-level output, output-enable and pull-up signals, and returns synchronised pad input to software.

## Interface
- WIDTH, 8: number of pins; also the data-bus width used by this block.
- SYNC_STAGES, 2: flip-flop stages on `pin_in` before any use. Legal range is ≥2.
- clock input 1: sole clock, rising edge.
- reset_n input 1: asynchronous, active-low reset.
- wr_en input 1: register write strobe, sampled on the rising edge of `clock`.
- addr input 3: register select.
  - 0: PIN. Read returns the synchronised input. Write-1 toggles the corresponding PORT bit.
  - 1: DDR.
  - 2: PORT.
  - 3: PCMSK, the pin-change mask.
  - 4: PCIF, flag in bit 0, write-1-to-clear.
  - 5–7: reserved.
- wdata input WIDTH: write data.
- rdata output WIDTH: read data, combinational from `addr`.
- pin_in input WIDTH: asynchronous pad inputs.
- pin_out output WIDTH: equals PORT.
- pin_oe output WIDTH: equals DDR. 1 means output.
- pin_pullup output WIDTH: ~DDR & PORT.
- irq output 1: equals PCIF. Level, active-high.

## Operation
- Reset (reset_n=0, asynchronous): clears DDR, PORT, PCMSK, PCIF, all sync stages and the previous-sample register to 0. All outputs read 0 while reset is held.
- Register writes, when wr_en=1 on a rising edge:
  - addr 1: DDR←wdata.
  - addr 2: PORT←wdata.
  - addr 3: PCMSK←wdata.
  - addr 0: PORT←PORT ^ wdata. DDR is unaffected.
  - addr 4: if wdata[0]=1, PCIF←0.
  - addr 5–7: ignored.
- Reads, combinational:
  - addr 0: sync_q, the last sync stage.
  - addr 1: DDR. addr 2: PORT. addr 3: PCMSK.
  - addr 4: {0…, PCIF}.
  - addr 5–7: 0.
- PIN reads the pad regardless of DDR, so output pins read back their driven value after synchronisation.
- Synchroniser: SYNC_STAGES-deep shift per bit. prev_q←sync_q every cycle.
- Pin-change detect: change = (sync_q ^ prev_q) & PCMSK. If any bit of change is 1, PCIF←1 on the next edge.
- Simultaneous PCIF set and write-1-to-clear in the same cycle: set wins and PCIF stays 1.
- Mask applies at detection time. Changes on unmasked bits are lost; they are not queued.
- PCIF is sticky until software clears it. Repeated changes do not produce multiple flags.

## Timing
- Register write to pin_out / pin_oe / pin_pullup: visible 1 cycle after the write edge.
- pin_in step to PIN readable: SYNC_STAGES rising edges.
- pin_in step to irq high: SYNC_STAGES+1 edges, assuming the bit is masked in.
- A pulse on pin_in shorter than one clock period may be missed. Pulses ≥2 periods are always detected.
- Write-1-to-clear of PCIF: irq low 1 cycle after the write edge, unless a new change is detected on the same edge.
- Reset deasserted mid-operation: the synchroniser restarts from 0. A pin already high produces a change event after SYNC_STAGES+1 edges, but PCMSK=0 after reset suppresses it.
- No handshake: every write completes in one cycle and reads have zero latency.

## Test plan
- Reset state: hold reset_n=0 with pin_in=0xFF. Required: pin_out=pin_oe=pin_pullup=0x00 and irq=0. After release, reading addr 0 returns 0xFF after 2 edges.
- DDR/PORT/pull-up: write DDR=0x0F, then PORT=0xA5. Required: next cycle pin_out=0xA5, pin_oe=0x0F, pin_pullup=0xA0.
- Toggle: with PORT=0xA5, write addr 0 with 0xFF. Required: PORT=0x5A. Write addr 0 with 0x00. Required: no change.
- Pin-change interrupt: set PCMSK=0x01, then change pin_in bit0 from 0 to 1. Required: irq=1 exactly 3 edges later. A change on bit1 alone leaves irq=0.
- Clear vs set race: keep bit0 toggling every cycle and write 1 to addr 4. Required: irq stays 1. Stop toggling and write 1 to addr 4. Required: irq=0 next cycle.
- Reserved/width: with WIDTH=16, read addr 5. Required: 0x0000. Write addr 6: no register changes. Repeat the toggle test with 0xFFFF on all 16 bits.

Source files
------------

// File: rtl/gpio_port.sv
// gpio_port: AVR-style GPIO port (DDR/PORT/PIN, toggle-on-PIN-write, pull-ups, masked pin-change irq).
// Latency: register writes reach the pads 1 cycle after the write edge; PIN readback takes SYNC_STAGES edges; irq takes SYNC_STAGES+1 edges.
// Backpressure: none. Every write completes in one cycle and reads are combinational from addr.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] pin_pullup,
  output logic             irq
);

  localparam logic [2:0] ADDR_PIN   = 3'd0;
  localparam logic [2:0] ADDR_DDR   = 3'd1;
  localparam logic [2:0] ADDR_PORT  = 3'd2;
  localparam logic [2:0] ADDR_PCMSK = 3'd3;
  localparam logic [2:0] ADDR_PCIF  = 3'd4;

  // Software-visible state
  logic [WIDTH-1:0] ddr_q;
  logic [WIDTH-1:0] port_q;
  logic [WIDTH-1:0] pcmsk_q;
  logic             pcif_q;

  // Input synchroniser; the last stage is the only copy of the pads the rest of the block sees
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Write strobes and pin-change detection
  logic             wr_pin;
  logic             wr_ddr;
  logic             wr_port;
  logic             wr_pcmsk;
  logic             wr_pcif;
  logic [WIDTH-1:0] pc_change;
  logic             pc_event;

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Decode the register write strobes; reserved addresses decode to nothing
  always_comb begin
    wr_pin   = wr_en && (addr == ADDR_PIN);
    wr_ddr   = wr_en && (addr == ADDR_DDR);
    wr_port  = wr_en && (addr == ADDR_PORT);
    wr_pcmsk = wr_en && (addr == ADDR_PCMSK);
    wr_pcif  = wr_en && (addr == ADDR_PCIF);
  end

  // Edge on any masked-in bit of the synchronised input; the mask applies now, nothing is queued
  always_comb begin
    pc_change = (sync_q ^ prev_q) & pcmsk_q;
    pc_event  = |pc_change;
  end

  // Shift pads through the synchroniser and keep the previous sample for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_r[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_q <= sync_q;
    end
  end

  // Direction register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ddr_q <= '0;
    end else if (wr_ddr) begin
      ddr_q <= wdata;
    end
  end

  // Output data register: direct write, or write-1-to-toggle through the PIN address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port_q <= '0;
    end else if (wr_port) begin
      port_q <= wdata;
    end else if (wr_pin) begin
      port_q <= port_q ^ wdata;
    end
  end

  // Pin-change mask
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcmsk_q <= '0;
    end else if (wr_pcmsk) begin
      pcmsk_q <= wdata;
    end
  end

  // Sticky pin-change flag; a detection on the same edge as a clear wins so no event is lost
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcif_q <= 1'b0;
    end else if (pc_event) begin
      pcif_q <= 1'b1;
    end else if (wr_pcif && wdata[0]) begin
      pcif_q <= 1'b0;
    end
  end

  // Read mux; PIN returns the synchronised pad regardless of direction
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PIN:   rdata = sync_q;
      ADDR_DDR:   rdata = ddr_q;
      ADDR_PORT:  rdata = port_q;
      ADDR_PCMSK: rdata = pcmsk_q;
      ADDR_PCIF:  rdata[0] = pcif_q;
      default:    rdata = '0;
    endcase
  end

  // Pad-side outputs; pull-ups only on pins configured as inputs with PORT set
  always_comb begin
    pin_out    = port_q;
    pin_oe     = ddr_q;
    pin_pullup = ~ddr_q & port_q;
    irq        = pcif_q;
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: scoreboard bench for gpio_port, default 8-bit instance and a 16-bit instance sharing the register bus.
// Latency: expectations carry the cycle they are due on and are compared on the falling edge of that cycle.
// Backpressure: none; the bench drives one bus operation per cycle.
module tb_gpio_port;

  logic        clock;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] pin_v;

  logic [7:0]  rdata8, pin_out8, pin_oe8, pin_pullup8;
  logic        irq8;
  logic [15:0] rdata16, pin_out16, pin_oe16, pin_pullup16;
  logic        irq16;

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata[7:0]),
    .rdata      (rdata8),
    .pin_in     (pin_v[7:0]),
    .pin_out    (pin_out8),
    .pin_oe     (pin_oe8),
    .pin_pullup (pin_pullup8),
    .irq        (irq8)
  );

  gpio_port #(.WIDTH(16), .SYNC_STAGES(2)) u_dut16 (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata16),
    .pin_in     (pin_v),
    .pin_out    (pin_out16),
    .pin_oe     (pin_oe16),
    .pin_pullup (pin_pullup16),
    .irq        (irq16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed-signal selectors
  localparam int S_RD8  = 0;
  localparam int S_OUT8 = 1;
  localparam int S_OE8  = 2;
  localparam int S_PU8  = 3;
  localparam int S_IRQ8 = 4;
  localparam int S_RD16 = 5;
  localparam int S_OUT16 = 6;
  localparam int S_IRQ16 = 7;
  localparam int S_OE16 = 8;
  localparam int S_PU16 = 9;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  string tags[10] = '{"rdata8", "pin_out8", "pin_oe8", "pin_pullup8", "irq8",
                      "rdata16", "pin_out16", "irq16", "pin_oe16", "pin_pullup16"};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_RD8:   return {8'h00, rdata8};
      S_OUT8:  return {8'h00, pin_out8};
      S_OE8:   return {8'h00, pin_oe8};
      S_PU8:   return {8'h00, pin_pullup8};
      S_IRQ8:  return {15'h0, irq8};
      S_RD16:  return rdata16;
      S_OUT16: return pin_out16;
      S_IRQ16: return {15'h0, irq16};
      S_OE16:  return pin_oe16;
      S_PU16:  return pin_pullup16;
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Push an expectation due dly rising edges from now
  task automatic expect_at(input int sel, input logic [15:0] val, input int dly);
    exp_t e;
    e.due = cyc + dly;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare every expectation that falls due on this cycle, away from the active edge
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk_eq(tags[sb[i].sel], obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e8, input logic [15:0] e16);
    addr = a;
    expect_at(S_RD8, e8, 0);
    expect_at(S_RD16, e16, 0);
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    addr    = 3'd0;
    wdata   = 16'h0;
    pin_v   = 16'hFFFF;
    tick(2);

    // Reset held with all pads high: every output low, PIN not yet visible
    expect_at(S_OUT8, 16'h0, 0);
    expect_at(S_OE8, 16'h0, 0);
    expect_at(S_PU8, 16'h0, 0);
    expect_at(S_IRQ8, 16'h0, 0);
    expect_at(S_OUT16, 16'h0, 0);
    expect_at(S_IRQ16, 16'h0, 0);
    expect_at(S_RD8, 16'h0, 0);
    tick(1);

    // Release: PIN readable after exactly two edges
    reset_n = 1'b1;
    expect_at(S_RD8, 16'h0000, 1);
    expect_at(S_RD8, 16'h00FF, 2);
    expect_at(S_RD16, 16'hFFFF, 2);
    expect_at(S_IRQ8, 16'h0, 4);
    tick(5);

    // Drop the pads; PCMSK is still 0 so no flag
    pin_v = 16'h0000;

    // DDR / PORT / pull-up
    wr(3'd1, 16'h000F);
    wr(3'd2, 16'h00A5);
    expect_at(S_OUT8, 16'h00A5, 0);
    expect_at(S_OE8, 16'h000F, 0);
    expect_at(S_PU8, 16'h00A0, 0);
    expect_at(S_PU16, 16'h00A0, 0);
    expect_at(S_OE16, 16'h000F, 0);
    rd(3'd1, 16'h000F, 16'h000F);
    rd(3'd2, 16'h00A5, 16'h00A5);

    // Toggle through the PIN address
    wr(3'd0, 16'h00FF);
    expect_at(S_OUT8, 16'h005A, 0);
    expect_at(S_OUT16, 16'h005A, 0);
    expect_at(S_PU8, 16'h0050, 0);
    wr(3'd0, 16'h0000);
    expect_at(S_OUT8, 16'h005A, 0);
    expect_at(S_OE8, 16'h000F, 0);
    rd(3'd0, 16'h0000, 16'h0000);
    tick(1);

    // Pin-change interrupt on a masked-in bit: irq exactly 3 edges after the step
    wr(3'd3, 16'h0001);
    expect_at(S_IRQ8, 16'h0, 0);
    pin_v = 16'h0001;
    expect_at(S_IRQ8, 16'h0, 0);
    expect_at(S_IRQ8, 16'h0, 1);
    expect_at(S_IRQ8, 16'h0, 2);
    expect_at(S_IRQ8, 16'h1, 3);
    expect_at(S_IRQ16, 16'h1, 3);
    tick(4);
    rd(3'd4, 16'h0001, 16'h0001);
    rd(3'd0, 16'h0001, 16'h0001);
    wr(3'd4, 16'h0002);
    expect_at(S_IRQ8, 16'h1, 0);
    wr(3'd4, 16'h0001);
    expect_at(S_IRQ8, 16'h0, 0);
    expect_at(S_IRQ16, 16'h0, 0);
    tick(1);

    // A change on a masked-out bit is lost
    pin_v = 16'h0003;
    for (int d = 0; d < 6; d++) begin
      expect_at(S_IRQ8, 16'h0, d);
    end
    expect_at(S_IRQ16, 16'h0, 5);
    tick(7);

    // Clear racing a fresh detection: the set wins
    for (int i = 0; i < 10; i++) begin
      pin_v = pin_v ^ 16'h0001;
      if (i == 9) begin
        wr_en = 1'b1;
        addr  = 3'd4;
        wdata = 16'h0001;
      end
      tick(1);
    end
    wr_en = 1'b0;
    expect_at(S_IRQ8, 16'h1, 0);
    expect_at(S_IRQ16, 16'h1, 0);
    tick(4);
    wr(3'd4, 16'h0001);
    expect_at(S_IRQ8, 16'h0, 0);
    expect_at(S_IRQ16, 16'h0, 0);
    expect_at(S_RD8, 16'h0000, 0);
    tick(1);

    // Reserved addresses read 0 and ignore writes
    rd(3'd5, 16'h0000, 16'h0000);
    rd(3'd7, 16'h0000, 16'h0000);
    wr(3'd6, 16'hFFFF);
    wr(3'd5, 16'hFFFF);
    wr(3'd7, 16'hFFFF);
    rd(3'd1, 16'h000F, 16'h000F);
    rd(3'd2, 16'h005A, 16'h005A);
    rd(3'd3, 16'h0001, 16'h0001);

    // Full-width toggle
    wr(3'd0, 16'hFFFF);
    expect_at(S_OUT8, 16'h00A5, 0);
    expect_at(S_OUT16, 16'hFFA5, 0);
    expect_at(S_PU16, 16'hFFA0, 0);
    wr(3'd0, 16'h0000);
    expect_at(S_OUT16, 16'hFFA5, 0);
    wr(3'd0, 16'hFFFF);
    expect_at(S_OUT8, 16'h005A, 0);
    expect_at(S_OUT16, 16'h005A, 0);
    tick(1);

    // Asynchronous reset mid-operation with irq raised
    pin_v = pin_v ^ 16'h0001;
    tick(4);
    expect_at(S_IRQ8, 16'h1, 0);
    tick(1);
    reset_n = 1'b0;
    addr    = 3'd0;
    expect_at(S_OUT8, 16'h0, 0);
    expect_at(S_OE8, 16'h0, 0);
    expect_at(S_IRQ8, 16'h0, 0);
    expect_at(S_OUT16, 16'h0, 0);
    expect_at(S_IRQ16, 16'h0, 0);
    expect_at(S_RD16, 16'h0, 0);
    tick(2);

    // Pads high at release: the resulting change is masked off by PCMSK=0
    reset_n = 1'b1;
    pin_v   = 16'hFFFF;
    for (int d = 0; d < 7; d++) begin
      expect_at(S_IRQ8, 16'h0, d);
    end
    expect_at(S_IRQ16, 16'h0, 6);
    expect_at(S_RD16, 16'hFFFF, 6);
    tick(8);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      tick(1);
    end
    while (sb.size() != 0) begin
      chk_eq("sb_drain", 16'h0000, 16'hFFFF);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
